router: RTL
===========

Name: router

Overview:
- Demultiplexing counterpart to the Arbiter on the same val/rdy bus.
- Accepts one address-headed stream of {addr, data} words, strips the address header and delivers the data word to the output port selected by that address.
- Each output has a one-entry registered buffer, so downstream consumers stall independently and throughput stays at one word per cycle.
- Sits between the SPI-side val/rdy wrapper and the set of accelerator components that receive requests.

Parameters:
- nbits, 32, width of the data payload delivered to each output.
- noutputs, 3, number of output ports; must be >= 2.
- addr_nbits, $clog2(noutputs), width of the address header on the input message.
- cnt_nbits, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- istream_val  input  1  input message valid.
- istream_rdy  output  1  router can accept the input message this cycle.
- istream_msg  input  addr_nbits+nbits  {addr[addr_nbits-1:0], data[nbits-1:0]}; the address is in the MSBs.
- ostream_val  output  1 [0:noutputs-1]  per-output valid.
- ostream_rdy  input  1 [0:noutputs-1]  per-output ready.
- ostream_msg  output  nbits [0:noutputs-1]  per-output data, header stripped.
- drop_count  output  cnt_nbits  number of input messages discarded for an out-of-range address; saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - all buffers empty (full[j]=0, data[j]=0);
  - drop_count=0;
  - therefore ostream_val[j]=0 and ostream_msg[j]=0 for every j.
  - Reset asserted mid-transfer discards any buffered words immediately; nothing is replayed after reset.
- Decode: addr = istream_msg[addr_nbits+nbits-1:nbits]; data = istream_msg[nbits-1:0].
- Outputs are driven directly from registers: ostream_val[j]=full[j] and ostream_msg[j]=data[j].
- istream_rdy (combinational from istream_msg and ostream_rdy; never depends on istream_val):
  - addr < noutputs: istream_rdy = !full[addr] | ostream_rdy[addr];
  - addr >= noutputs: istream_rdy = 1, so invalid messages are always consumed.
- Per-output buffer j, evaluated at the clock edge; fire_in_j = istream_val & istream_rdy & (addr==j):
  - fire_in_j: data[j] <= data and full[j] <= 1. This covers the simultaneous drain-and-load case, which keeps the output valid with the new word.
  - else if full[j] & ostream_rdy[j]: full[j] <= 0. data[j] keeps its value.
  - else: hold.
- Latency: an accepted word appears on ostream one cycle after the input handshake.
- Throughput: one word per cycle to a single output whose consumer holds ostream_rdy=1.
- Ordering: words to the same output are delivered in acceptance order. No ordering relation is guaranteed across different outputs.
- Blocking: the input is head-of-line blocked. A message to a full, stalled output holds istream_rdy=0 and blocks all other traffic. This is intentional and mirrors the Arbiter's single-stream behaviour.
- Out-of-range address (possible only when noutputs is not a power of 2):
  - on the handshake the message is dropped and no buffer changes;
  - drop_count increments by 1 and saturates at 2^cnt_nbits-1, never wrapping.
- Back-pressure protocol:
  - once ostream_val[j]=1, data[j] is stable until the handshake;
  - ostream_val never depends combinationally on ostream_rdy.
- The router never modifies the data payload.

Decomposition:
- Shared package `router_pkg` holds:
  - a helper to compute addr_nbits from noutputs;
  - a localparam for the drop-counter saturation value.
- One natural sub-module, `router_obuf`: a single-entry val/rdy pipeline buffer with asynchronous reset, inputs load_en and load_data.
  - Instantiated noutputs times in a generate loop.
  - The top level holds decode, istream_rdy selection and the drop counter.

Test Plan (nbits=32, noutputs=3, addr_nbits=2):
- Reset check: assert reset asynchronously mid-cycle -> ostream_val={0,0,0}, ostream_msg all 0 and drop_count=0 before the next posedge; istream_rdy=1 for any address.
- Basic routing: send {2'd1, 32'hDEADBEEF} with all ostream_rdy=1 -> the next cycle ostream_val[1]=1 and ostream_msg[1]=32'hDEADBEEF, while ostream_val[0] and ostream_val[2] stay 0.
- Streaming: send {0,32'h1},{0,32'h2},{0,32'h3} back-to-back with ostream_rdy[0]=1 -> istream_rdy stays 1 and ostream_msg[0] shows 1,2,3 on consecutive cycles.
- Stall/blocking: hold ostream_rdy[2]=0, then send {2,32'hA} followed by {2,32'hB} -> the first is accepted; the second sees istream_rdy=0 until ostream_rdy[2]=1. The output shows A, then B one cycle after B's handshake.
- Invalid address: send {2'd3, 32'h55} four times -> istream_rdy=1 each time, no ostream_val asserts, drop_count=4. Then force 300 drops -> drop_count holds at 255.
- Interleave plus reset: load outputs 0 and 1, assert reset before draining -> both ostream_val deassert immediately, and the next accepted word appears with 1-cycle latency.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router and its output buffers.
//   addr_width()   - address header width needed to select one of n outputs
//   DROP_CNT_NBITS - default width of the out-of-range drop counter
//   DROP_CNT_MAX   - saturation value of a counter of the default width
package router_pkg;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned                 DROP_CNT_NBITS = 8;
   localparam logic [DROP_CNT_NBITS-1:0]   DROP_CNT_MAX   = '1;

endpackage

// File: rtl/router_obuf.sv
// router_obuf: single-entry val/rdy pipeline buffer for one router output.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   load_en, load_data  - write strobe and word from the router front end
//   ostream_val         - buffer holds a word (registered)
//   ostream_rdy         - downstream consumer takes the word this cycle
//   ostream_msg         - buffered word (registered)
module router_obuf #(
   parameter int unsigned nbits = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [nbits-1:0] load_data,
   output logic             ostream_val,
   input  logic             ostream_rdy,
   output logic [nbits-1:0] ostream_msg
);

   // A load wins over a drain, so a same-cycle drain-and-load keeps the
   // output valid with the new word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ostream_val <= 1'b0;
         ostream_msg <= '0;
      end else if (load_en) begin
         ostream_val <= 1'b1;
         ostream_msg <= load_data;
      end else if (ostream_val && ostream_rdy) begin
         ostream_val <= 1'b0;
      end
   end

endmodule

// File: rtl/router.sv
// router: strips the address header from each {addr, data} input word and
// delivers the data word to the output selected by addr. Each output has a
// one-entry buffer; the input is head-of-line blocked by a stalled output.
// Words addressed beyond noutputs are consumed and counted in drop_count.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   istream_val/rdy/msg        - input stream, msg = {addr, data}
//   ostream_val/rdy/msg [j]    - per-output streams, header stripped
//   drop_count                 - saturating count of out-of-range messages
module router
   import router_pkg::*;
#(
   parameter int unsigned nbits      = 32,
   parameter int unsigned noutputs   = 3,
   parameter int unsigned addr_nbits = addr_width(noutputs),
   parameter int unsigned cnt_nbits  = DROP_CNT_NBITS
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        istream_val,
   output logic                        istream_rdy,
   input  logic [addr_nbits+nbits-1:0] istream_msg,
   output logic                        ostream_val [0:noutputs-1],
   input  logic                        ostream_rdy [0:noutputs-1],
   output logic [nbits-1:0]            ostream_msg [0:noutputs-1],
   output logic [cnt_nbits-1:0]        drop_count
);

   localparam logic [addr_nbits:0]  NOUT    = (addr_nbits+1)'(noutputs);
   localparam logic [cnt_nbits-1:0] CNT_MAX = '1;

   logic [addr_nbits-1:0] addr;
   logic [nbits-1:0]      data;
   logic                  addr_ok;
   logic                  fire;
   logic [noutputs-1:0]   load_en;

   assign addr    = istream_msg[addr_nbits+nbits-1:nbits];
   assign data    = istream_msg[nbits-1:0];
   assign addr_ok = {1'b0, addr} < NOUT;
   assign fire    = istream_val && istream_rdy;

   // Out-of-range addresses leave istream_rdy at 1 so they are always consumed.
   always_comb begin
      istream_rdy = 1'b1;
      load_en     = '0;
      for (int unsigned j = 0; j < noutputs; j++) begin
         if (addr_ok && addr == addr_nbits'(j))
            istream_rdy = !ostream_val[j] || ostream_rdy[j];
      end
      for (int unsigned j = 0; j < noutputs; j++) begin
         load_en[j] = istream_val && istream_rdy && addr_ok && addr == addr_nbits'(j);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_count <= '0;
      else if (fire && !addr_ok && drop_count != CNT_MAX)
         drop_count <= drop_count + 1'b1;
   end

   for (genvar j = 0; j < noutputs; j++) begin : g_obuf
      router_obuf #(
         .nbits (nbits)
      ) u_obuf (
         .clk         (clk),
         .reset       (reset),
         .load_en     (load_en[j]),
         .load_data   (data),
         .ostream_val (ostream_val[j]),
         .ostream_rdy (ostream_rdy[j]),
         .ostream_msg (ostream_msg[j])
      );
   end

endmodule
